program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Writer side of instruction memory: receives a program as a byte stream (valid/ready),
//  packs bytes little-endian into 32-bit words and writes them to imem from address 0.
//  Holds the datapath in reset while loading; releases it once the all-zero terminator
//  word is stored, since the core halts when it fetches instruction 0.
// PARAMETERS
//  ADDR_W  5   imem word-address width
//  DEPTH   32  imem words; must be <= 2**ADDR_W
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         asynchronous, active-high reset
//  start       in   1         single-cycle pulse; begins a load (IDLE or DONE only)
//  byte_in     in   8         program byte
//  byte_valid  in   1         byte_in is valid
//  byte_ready  out  1         loader accepts a byte this cycle
//  imem_we     out  1         imem write strobe, one cycle per word
//  imem_addr   out  ADDR_W    imem word address
//  imem_wdata  out  32        packed instruction word
//  core_rst    out  1         reset to datapath; 1 = hold core
//  done        out  1         load complete, terminator stored
//  overflow    out  1         DEPTH words written with no terminator
//  word_count  out  ADDR_W+1  words written in current load, terminator included
// BEHAVIOUR
//  - rst: state=IDLE; core_rst=1; all other outputs 0; byte idx, wptr, word buffer cleared.
//  - States: IDLE, RECV, WRITE, DONE, ERR. Registered outputs, decoded from state/counters.
//  - IDLE: byte_ready=0, core_rst=1. start -> RECV; wptr=0, idx=0, word_count=0.
//  - RECV: byte_ready=1. On byte_valid&&byte_ready: buf[8*idx+:8]<=byte_in, idx++.
//    Accepting byte with idx==3 -> WRITE next cycle, idx wraps to 0. byte_valid held
//    low: stay in RECV, no state change. start ignored.
//  - WRITE (1 cycle): imem_we=1, imem_addr=wptr, imem_wdata=buf, byte_ready=0; word_count++.
//    buf==0 -> DONE. Else if wptr==DEPTH-1 -> ERR, overflow=1. Else wptr++, -> RECV.
//  - DONE: core_rst=0, done=1, byte_ready=0. start -> RECV, same edge core_rst=1, done=0,
//    counters cleared.
//  - ERR: core_rst=1, overflow=1, byte_ready=0; exit only via rst or start -> RECV
//    (clears overflow and counters).
//  - Latency: imem write occurs the cycle after 4th byte accepted. Throughput: at most
//    4 bytes per 5 cycles.
//  - imem_addr/imem_wdata are don't-care when imem_we=0 and must not glitch imem_we.
//  - rst mid-load: immediate return to IDLE, core_rst=1, partial word discarded; words
//    already written stay in imem.
//  - byte_valid in IDLE/WRITE/DONE/ERR is not accepted; the source holds it.
// TESTING
//  1. rst, start, bytes 13 05 10 00 00 00 00 00 -> imem[0]=32'h00100513, imem[1]=0;
//     word_count=2; done=1, core_rst=0 one cycle after 2nd write.
//  2. Backpressure: byte_valid toggling 1/0 over 3-word program -> 3 writes, byte_ready=0
//     in each WRITE cycle, no byte lost or duplicated.
//  3. 32 non-zero words, no terminator -> writes to addr 0..31, overflow=1, core_rst stays 1.
//  4. rst asserted after 2 bytes of word 1 -> IDLE same cycle, core_rst=1, no imem_we;
//     new start reloads from addr 0.
//  5. start in DONE with new 1-word program (00000000) -> core_rst=1 next edge, imem[0]=0,
//     done=1, word_count=1.
//  6. start pulse during RECV -> ignored, wptr and idx unchanged.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bundle of the program loader.
// The master modport is the loader side; slave is the byte source plus imem.
interface program_loader_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to imem from
// address 0, holding the core in reset until the all-zero terminator word is stored.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  program_loader_if.master     bus,
  output logic                 core_rst,
  output logic                 done,
  output logic                 overflow,
  output logic [ADDR_W:0]      word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W:0]   wc_q, wc_d;

  logic byte_ready_q, byte_ready_d;
  logic imem_we_q, imem_we_d;
  logic core_rst_q, core_rst_d;
  logic done_q, done_d;
  logic overflow_q, overflow_d;

  logic accept;
  assign accept = byte_ready_q & bus.byte_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wptr_q       <= '0;
      buf_q        <= '0;
      wc_q         <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wptr_q       <= wptr_d;
      buf_q        <= buf_d;
      wc_q         <= wc_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wptr_d  = wptr_q;
    buf_d   = buf_q;
    wc_d    = wc_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_RECV;
          idx_d   = '0;
          wptr_d  = '0;
          wc_d    = '0;
        end
      end
      S_RECV: begin
        if (accept) begin
          buf_d[{idx_q, 3'b000} +: 8] = bus.byte_in;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wc_d = wc_q + 1'b1;
        if (buf_q == '0) begin
          state_d = S_DONE;
        end else if (wptr_q == LAST_ADDR) begin
          state_d = S_ERR;
        end else begin
          wptr_d  = wptr_q + 1'b1;
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so imem_we is a clean flop.
  always_comb begin
    byte_ready_d = (state_d == S_RECV);
    imem_we_d    = (state_d == S_WRITE);
    core_rst_d   = (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    overflow_d   = (state_d == S_ERR);
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = wptr_q;
  assign bus.imem_wdata = buf_q;
  assign core_rst       = core_rst_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign word_count     = wc_q;

endmodule
